magnapinna_accum_unit: RTL and testbench

Parametrised, registered successor to the team's combinational byte adder. Takes two unsigned operands through a valid/ready handshake and updates an internal accumulator in one of four modes: load-sum, accumulate, subtract, or multiply-accumulate. Saturation or wrap-around is chosen per build. Results are presented through a one-entry output register with backpressure. The unit sits behind the Tiny Tapeout pin wrapper, which maps `ui_in`/`uio_in` to the operands.

---
 rtl/magnapinna_accum_unit.sv | 122 ++++++++++++
 tb/tb_magnapinna_accum_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/magnapinna_accum_unit.sv
// Registered accumulator with valid/ready handshake on both sides.
// Modes: ADD (a+b), ACC (acc+a), SUB (acc-a), MAC (acc+a*b). Out-of-range
// results either clamp or wrap depending on SATURATE; both set a sticky flag.
// ACC_WIDTH must be at least 2*WIDTH so that every raw result fits in
// ACC_WIDTH+1 bits and the top bit alone flags carry or borrow.
module magnapinna_accum_unit #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ACC_WIDTH = 16,
  parameter bit          SATURATE  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [1:0]           mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] result,
  output logic                 overflow,
  output logic [7:0]           count
);

  localparam int unsigned XW = ACC_WIDTH + 1;

  localparam logic [1:0] MODE_ADD = 2'b00;
  localparam logic [1:0] MODE_ACC = 2'b01;
  localparam logic [1:0] MODE_SUB = 2'b10;
  localparam logic [1:0] MODE_MAC = 2'b11;

  logic [ACC_WIDTH-1:0] r_acc;
  logic                 r_overflow;
  logic [7:0]           r_count;
  logic                 r_out_valid;

  logic                 w_accept;
  logic [2*WIDTH-1:0]   w_prod;
  logic [XW-1:0]        w_a_x;
  logic [XW-1:0]        w_b_x;
  logic [XW-1:0]        w_acc_x;
  logic [XW-1:0]        w_prod_x;
  logic [XW-1:0]        w_raw;
  logic                 w_is_sub;
  logic                 w_range;
  logic [ACC_WIDTH-1:0] w_next_acc;

  // Stalling input while an unconsumed result is held keeps result stable.
  assign in_ready = !clear && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;

  assign w_prod   = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
  assign w_a_x    = XW'(a);
  assign w_b_x    = XW'(b);
  assign w_acc_x  = {1'b0, r_acc};
  assign w_prod_x = XW'(w_prod);

  // Raw arithmetic one bit wider than the accumulator; top bit is carry/borrow.
  always_comb begin
    w_raw    = '0;
    w_is_sub = 1'b0;
    case (mode)
      MODE_ADD: w_raw = w_a_x + w_b_x;
      MODE_ACC: w_raw = w_acc_x + w_a_x;
      MODE_SUB: begin
        w_raw    = w_acc_x - w_a_x;
        w_is_sub = 1'b1;
      end
      MODE_MAC: w_raw = w_acc_x + w_prod_x;
      default:  w_raw = '0;
    endcase
  end

  assign w_range = w_raw[XW-1];

  // Clamp toward the violated bound when saturating, otherwise keep low bits.
  always_comb begin
    w_next_acc = w_raw[ACC_WIDTH-1:0];
    if (w_range && SATURATE) begin
      w_next_acc = w_is_sub ? '0 : '1;
    end
  end

  // Accumulator, sticky overflow and beat counter; clear beats any accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc      <= '0;
      r_overflow <= 1'b0;
      r_count    <= 8'd0;
    end else if (clear) begin
      r_acc      <= '0;
      r_overflow <= 1'b0;
      r_count    <= 8'd0;
    end else if (w_accept) begin
      r_acc      <= w_next_acc;
      r_overflow <= r_overflow | w_range;
      if (r_count != 8'hFF) begin
        r_count <= r_count + 8'd1;
      end
    end
  end

  // Output valid bit: set on accept, dropped when consumed without a new beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
    end else if (clear) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_acc;
  assign overflow  = r_overflow;
  assign count     = r_count;

endmodule

// File: tb/tb_magnapinna_accum_unit.sv
// Directed bench: a saturating and a wrapping instance driven in lockstep,
// checked against a scoreboard filled by a small integer model.
module tb_magnapinna_accum_unit;

  localparam int unsigned W    = 8;
  localparam int unsigned AW   = 16;
  localparam longint      MAXV = 65535;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [1:0]    mode = 2'b00;

  logic          in_ready_s, out_valid_s, overflow_s;
  logic [AW-1:0] result_s;
  logic [7:0]    count_s;
  logic          in_ready_w, out_valid_w, overflow_w;
  logic [AW-1:0] result_w;
  logic [7:0]    count_w;

  magnapinna_accum_unit #(.WIDTH(W), .ACC_WIDTH(AW), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_s),
    .a(a), .b(b), .mode(mode), .out_valid(out_valid_s), .out_ready(out_ready),
    .result(result_s), .overflow(overflow_s), .count(count_s)
  );

  magnapinna_accum_unit #(.WIDTH(W), .ACC_WIDTH(AW), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_w),
    .a(a), .b(b), .mode(mode), .out_valid(out_valid_w), .out_ready(out_ready),
    .result(result_w), .overflow(overflow_w), .count(count_w)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint rs;
    logic   os;
    longint rw;
    logic   ow;
    int     cnt;
  } exp_t;

  exp_t   sb[$];
  int     n_checks = 0;
  int     n_fail = 0;

  longint m_s, m_w;
  logic   mo_s, mo_w;
  int     m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s = 0; m_w = 0; mo_s = 1'b0; mo_w = 1'b0; m_cnt = 0;
    sb.delete();
  endtask

  // Apply one beat to one accumulator image.
  task automatic model_one(input logic [1:0] m, input longint aa, input longint bb,
                           input bit sat, inout longint acc, inout logic ovf);
    longint v;
    case (m)
      2'b00: v = aa + bb;
      2'b01: v = acc + aa;
      2'b10: v = acc - aa;
      default: v = acc + aa * bb;
    endcase
    if (v < 0) begin
      ovf = 1'b1;
      acc = sat ? 0 : v + MAXV + 1;
    end else if (v > MAXV) begin
      ovf = 1'b1;
      acc = sat ? MAXV : v - (MAXV + 1);
    end else begin
      acc = v;
    end
  endtask

  task automatic drive_beat(input logic [1:0] m, input logic [W-1:0] aa, input logic [W-1:0] bb);
    exp_t e;
    mode = m; a = aa; b = bb; in_valid = 1'b1;
    model_one(m, longint'(aa), longint'(bb), 1'b1, m_s, mo_s);
    model_one(m, longint'(aa), longint'(bb), 1'b0, m_w, mo_w);
    if (m_cnt < 255) m_cnt++;
    e.rs = m_s; e.os = mo_s; e.rw = m_w; e.ow = mo_w; e.cnt = m_cnt;
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_res_sat"},  32'(result_s),    32'(e.rs));
    chk({tag, "_ovf_sat"},  32'(overflow_s),  32'(e.os));
    chk({tag, "_res_wrap"}, 32'(result_w),    32'(e.rw));
    chk({tag, "_ovf_wrap"}, 32'(overflow_w),  32'(e.ow));
    chk({tag, "_cnt"},      32'(count_s),     32'(e.cnt));
    chk({tag, "_cnt_wrap"}, 32'(count_w),     32'(e.cnt));
    chk({tag, "_valid"},    32'(out_valid_s), 32'd1);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input string tag, input logic [1:0] m, input logic [W-1:0] aa,
                      input logic [W-1:0] bb);
    drive_beat(m, aa, bb);
    cyc();
    pop_check(tag);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_res_sat"},  32'(result_s),    32'd0);
    chk({tag, "_res_wrap"}, 32'(result_w),    32'd0);
    chk({tag, "_ovf"},      32'(overflow_s),  32'd0);
    chk({tag, "_ovf_wrap"}, 32'(overflow_w),  32'd0);
    chk({tag, "_cnt"},      32'(count_s),     32'd0);
    chk({tag, "_valid"},    32'(out_valid_s), 32'd0);
  endtask

  // Clear with a beat offered: the beat must be dropped.
  task automatic do_clear(input string tag);
    clear = 1'b1; in_valid = 1'b1; mode = 2'b01; a = 8'd9;
    #1;
    chk({tag, "_inready_during_clear"}, 32'(in_ready_s), 32'd0);
    cyc();
    clear = 1'b0; in_valid = 1'b0;
    model_reset();
    check_zero(tag);
  endtask

  initial begin
    model_reset();
    #12;
    check_zero("reset");
    rst_n = 1'b1;
    #1;
    chk("reset_in_ready", 32'(in_ready_s), 32'd1);
    @(negedge clk);

    // ADD 200+100
    beat("add", 2'b00, 8'd200, 8'd100);
    chk("add_300", 32'(result_s), 32'd300);
    in_valid = 1'b0;
    cyc();
    chk("valid_drop", 32'(out_valid_s), 32'd0);

    // MAC then ACC into saturation / wrap
    do_clear("clr1");
    beat("mac", 2'b11, 8'd255, 8'd255);
    chk("mac_65025", 32'(result_s), 32'd65025);
    beat("acc1", 2'b01, 8'd255, 8'd0);
    beat("acc2", 2'b01, 8'd255, 8'd0);
    chk("acc_65535", 32'(result_s), 32'd65535);
    beat("acc_ovf", 2'b01, 8'd1, 8'd0);
    chk("sat_clamp", 32'(result_s), 32'd65535);
    chk("wrap_zero", 32'(result_w), 32'd0);
    in_valid = 1'b0;

    // SUB underflow; clear also drops the sticky flag
    do_clear("clr2");
    beat("sub", 2'b10, 8'd5, 8'd0);
    chk("sub_sat0", 32'(result_s), 32'd0);
    chk("sub_wrap", 32'(result_w), 32'd65531);
    in_valid = 1'b0;

    // Backpressure
    do_clear("clr3");
    out_ready = 1'b0;
    beat("bp_first", 2'b01, 8'd7, 8'd0);
    a = 8'd9;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("bp_in_ready", 32'(in_ready_s), 32'd0);
      cyc();
      chk("bp_result", 32'(result_s), 32'd7);
      chk("bp_valid", 32'(out_valid_s), 32'd1);
    end
    out_ready = 1'b1;
    drive_beat(2'b01, 8'd9, 8'd0);
    #1;
    chk("bp_release_ready", 32'(in_ready_s), 32'd1);
    cyc();
    pop_check("bp_release");
    chk("bp_16", 32'(result_s), 32'd16);
    in_valid = 1'b0;

    // Streaming ACC 1..8
    do_clear("clr4");
    for (int i = 1; i <= 8; i++) begin
      beat("stream", 2'b01, 8'(i), 8'd0);
    end
    chk("stream_36", 32'(result_s), 32'd36);
    chk("stream_cnt8", 32'(count_s), 32'd8);

    // Clear while holding a valid result
    out_ready = 1'b0;
    in_valid = 1'b0;
    do_clear("clr_valid");
    out_ready = 1'b1;

    // Count saturation
    for (int i = 0; i < 260; i++) begin
      beat("cnt_sat", 2'b00, 8'd0, 8'd0);
    end
    chk("cnt_255", 32'(count_s), 32'd255);
    in_valid = 1'b0;

    // Asynchronous reset between edges
    beat("pre_rst", 2'b00, 8'd3, 8'd4);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    #1;
    rst_n = 1'b1;
    model_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
